scoreboard: RTL and testbench

Game-state tracker directly downstream of the batting pulse generator. Consumes the one-cycle `hit_pulse` / `out_pulse` events and maintains the bases, outs, half-inning, inning and per-team scores. It also detects end of game, including walk-off and extra innings. Outputs are registered and feed the display/LED drivers.

---
 rtl/baseball_pkg.sv | 33 +++
 rtl/runner_advance.sv | 39 +++
 rtl/scoreboard.sv | 187 ++++++++++++++++++
 tb/tb_scoreboard.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/baseball_pkg.sv
// Shared definitions for the batting pipeline: game FSM states, base bit
// positions and the hit-bit ordering agreed with the upstream pulse stage.
package baseball_pkg;

   typedef enum logic [1:0] {
      ST_PLAY   = 2'd0,
      ST_CHANGE = 2'd1,
      ST_OVER   = 2'd2
   } game_state_t;

   // Runner occupancy bit positions inside the 3-bit bases vector
   localparam int BASE_FIRST  = 0;
   localparam int BASE_SECOND = 1;
   localparam int BASE_THIRD  = 2;

   // hit_pulse is {hit1, hit2, hit3, hit4}: hit1 is the MSB
   localparam int HIT1_BIT = 3;
   localparam int HIT2_BIT = 2;
   localparam int HIT3_BIT = 1;
   localparam int HIT4_BIT = 0;

   localparam logic [3:0] HIT1_MASK = 4'(1 << HIT1_BIT);
   localparam logic [3:0] HIT2_MASK = 4'(1 << HIT2_BIT);
   localparam logic [3:0] HIT3_MASK = 4'(1 << HIT3_BIT);
   localparam logic [3:0] HIT4_MASK = 4'(1 << HIT4_BIT);

   localparam logic [3:0] INNING_MAX = 4'd15;

   function automatic logic [2:0] popcount4(input logic [3:0] v);
      return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
   endfunction

endpackage

// File: rtl/runner_advance.sv
// Combinational runner advancement: every runner and the batter move N bases
// for a hit-N; whoever passes third base scores.
module runner_advance
   import baseball_pkg::*;
(
   input  logic [2:0] bases,
   input  logic [3:0] hit,
   output logic [2:0] new_bases,
   output logic [2:0] runs
);

   logic [1:0] shift_amt;
   logic       hit_valid;
   logic [6:0] advanced;

   // Decode the one-hot hit into an advance distance and move the runners.
   // advanced holds the 8-bit shifted vector without its always-empty home
   // plate bit: [2:0] are the new bases, [6:3] are runners that crossed home.
   always_comb begin
      shift_amt = 2'd0;
      hit_valid = 1'b1;
      if (hit == HIT1_MASK)      shift_amt = 2'd0;
      else if (hit == HIT2_MASK) shift_amt = 2'd1;
      else if (hit == HIT3_MASK) shift_amt = 2'd2;
      else if (hit == HIT4_MASK) shift_amt = 2'd3;
      else                       hit_valid = 1'b0;

      advanced = {3'b000, bases, 1'b1} << shift_amt;

      if (hit_valid) begin
         new_bases = advanced[2:0];
         runs      = popcount4(advanced[6:3]);
      end else begin
         new_bases = bases;
         runs      = 3'd0;
      end
   end

endmodule

// File: rtl/scoreboard.sv
// Game-state tracker: consumes hit/out pulses and maintains bases, outs,
// half-inning, inning and both scores, and detects end of game including
// walk-offs and extra innings. All outputs are registered.
module scoreboard
   import baseball_pkg::*;
#(
   parameter int INNINGS = 9,
   parameter int SCORE_W = 5
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [3:0]         hit_pulse,
   input  logic               out_pulse,
   input  logic               new_game,
   output logic [2:0]         bases,
   output logic [1:0]         outs,
   output logic [3:0]         inning,
   output logic               bottom,
   output logic [SCORE_W-1:0] score_visitor,
   output logic [SCORE_W-1:0] score_home,
   output logic [2:0]         runs_scored,
   output logic               score_pulse,
   output logic               change_pulse,
   output logic               game_over
);

   localparam logic [3:0] INNINGS_REG = 4'(INNINGS);

   game_state_t        state_q, state_d;
   logic [2:0]         bases_q, bases_d;
   logic [1:0]         outs_q, outs_d;
   logic [3:0]         inning_q, inning_d;
   logic               bottom_q, bottom_d;
   logic [SCORE_W-1:0] vis_q, vis_d;
   logic [SCORE_W-1:0] home_q, home_d;
   logic [2:0]         runs_q, runs_d;
   logic               score_pulse_q, score_pulse_d;
   logic               change_pulse_q, change_pulse_d;
   logic               game_over_q, game_over_d;

   logic               event_valid;
   logic               is_hit;
   logic               is_out;
   logic [2:0]         adv_bases;
   logic [2:0]         adv_runs;

   function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                  input logic [2:0]         r);
      logic [SCORE_W:0] sum;
      sum = {1'b0, a} + (SCORE_W+1)'(r);
      if (sum[SCORE_W]) return '1;
      return sum[SCORE_W-1:0];
   endfunction

   runner_advance u_runner_advance (
      .bases     (bases_q),
      .hit       (hit_pulse),
      .new_bases (adv_bases),
      .runs      (adv_runs)
   );

   assign event_valid = $onehot({hit_pulse, out_pulse});
   assign is_hit      = event_valid && (hit_pulse != 4'd0);
   assign is_out      = event_valid && out_pulse;

   // Next-state and next-output logic: hold everything, strobes default low
   always_comb begin
      state_d        = state_q;
      bases_d        = bases_q;
      outs_d         = outs_q;
      inning_d       = inning_q;
      bottom_d       = bottom_q;
      vis_d          = vis_q;
      home_d         = home_q;
      runs_d         = runs_q;
      score_pulse_d  = 1'b0;
      change_pulse_d = 1'b0;
      game_over_d    = game_over_q;

      if (new_game) begin
         state_d     = ST_PLAY;
         bases_d     = 3'd0;
         outs_d      = 2'd0;
         inning_d    = 4'd1;
         bottom_d    = 1'b0;
         vis_d       = '0;
         home_d      = '0;
         runs_d      = 3'd0;
         game_over_d = 1'b0;
      end else begin
         unique case (state_q)
            ST_PLAY: begin
               if (is_hit) begin
                  bases_d       = adv_bases;
                  runs_d        = adv_runs;
                  score_pulse_d = 1'b1;
                  if (bottom_q) begin
                     home_d = sat_add(home_q, adv_runs);
                     // Walk-off: home takes the lead late in the game
                     if ((inning_q >= INNINGS_REG) && (home_d > vis_q)) begin
                        state_d     = ST_OVER;
                        game_over_d = 1'b1;
                     end
                  end else begin
                     vis_d = sat_add(vis_q, adv_runs);
                  end
               end else if (is_out) begin
                  if (outs_q == 2'd2) begin
                     outs_d         = 2'd3;
                     state_d        = ST_CHANGE;
                     change_pulse_d = 1'b1;
                  end else begin
                     outs_d = outs_q + 2'd1;
                  end
               end
            end

            ST_CHANGE: begin
               bases_d  = 3'd0;
               outs_d   = 2'd0;
               bottom_d = ~bottom_q;
               if (bottom_q && (inning_q != INNING_MAX)) inning_d = inning_q + 4'd1;
               state_d = ST_PLAY;
               // Top half done late with home ahead: bottom half is not played
               if (!bottom_q && (inning_q >= INNINGS_REG) && (home_q > vis_q)) begin
                  state_d     = ST_OVER;
                  game_over_d = 1'b1;
               end
               // Bottom half done late and not tied: decided
               if (bottom_q && (inning_q >= INNINGS_REG) && (home_q != vis_q)) begin
                  state_d     = ST_OVER;
                  game_over_d = 1'b1;
               end
            end

            ST_OVER: begin
               state_d = ST_OVER;
            end

            default: begin
               state_d = ST_PLAY;
            end
         endcase
      end
   end

   // Game state register with asynchronous clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= ST_PLAY;
         bases_q        <= 3'd0;
         outs_q         <= 2'd0;
         inning_q       <= 4'd1;
         bottom_q       <= 1'b0;
         vis_q          <= '0;
         home_q         <= '0;
         runs_q         <= 3'd0;
         score_pulse_q  <= 1'b0;
         change_pulse_q <= 1'b0;
         game_over_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         bases_q        <= bases_d;
         outs_q         <= outs_d;
         inning_q       <= inning_d;
         bottom_q       <= bottom_d;
         vis_q          <= vis_d;
         home_q         <= home_d;
         runs_q         <= runs_d;
         score_pulse_q  <= score_pulse_d;
         change_pulse_q <= change_pulse_d;
         game_over_q    <= game_over_d;
      end
   end

   assign bases         = bases_q;
   assign outs          = outs_q;
   assign inning        = inning_q;
   assign bottom        = bottom_q;
   assign score_visitor = vis_q;
   assign score_home    = home_q;
   assign runs_scored   = runs_q;
   assign score_pulse   = score_pulse_q;
   assign change_pulse  = change_pulse_q;
   assign game_over     = game_over_q;

endmodule

// File: tb/tb_scoreboard.sv
// Directed bench for the scoreboard: a table of single-event vectors for the
// top of the first inning, then hand-written multi-cycle game sequences.
module tb_scoreboard;

   localparam int INN = 2;
   localparam int SW  = 5;

   localparam logic [3:0] H1 = 4'b1000;
   localparam logic [3:0] H2 = 4'b0100;
   localparam logic [3:0] H3 = 4'b0010;
   localparam logic [3:0] H4 = 4'b0001;

   logic          clk;
   logic          reset_n;
   logic [3:0]    hit_pulse;
   logic          out_pulse;
   logic          new_game;
   logic [2:0]    bases;
   logic [1:0]    outs;
   logic [3:0]    inning;
   logic          bottom;
   logic [SW-1:0] score_visitor;
   logic [SW-1:0] score_home;
   logic [2:0]    runs_scored;
   logic          score_pulse;
   logic          change_pulse;
   logic          game_over;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [3:0]    hit;
      logic          out;
      logic [2:0]    bases;
      logic [1:0]    outs;
      logic [SW-1:0] sv;
      logic [2:0]    rs;
      logic          sp;
   } vec_t;

   vec_t tbl[14];

   scoreboard #(.INNINGS(INN), .SCORE_W(SW)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .hit_pulse     (hit_pulse),
      .out_pulse     (out_pulse),
      .new_game      (new_game),
      .bases         (bases),
      .outs          (outs),
      .inning        (inning),
      .bottom        (bottom),
      .score_visitor (score_visitor),
      .score_home    (score_home),
      .runs_scored   (runs_scored),
      .score_pulse   (score_pulse),
      .change_pulse  (change_pulse),
      .game_over     (game_over)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs, let the edge take them, sample 1ns later
   task automatic apply(input logic [3:0] h, input logic o, input logic ng);
      @(negedge clk);
      hit_pulse = h;
      out_pulse = o;
      new_game  = ng;
      @(posedge clk);
      #1;
      hit_pulse = 4'd0;
      out_pulse = 1'b0;
      new_game  = 1'b0;
   endtask

   // Three outs then the CHANGE cycle, leaving the next half-inning open
   task automatic half_inning_outs();
      apply(4'd0, 1'b1, 1'b0);
      apply(4'd0, 1'b1, 1'b0);
      apply(4'd0, 1'b1, 1'b0);
      apply(4'd0, 1'b0, 1'b0);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, ".bases"},  bases, 0);
      chk({tag, ".outs"},   outs, 0);
      chk({tag, ".inning"}, inning, 1);
      chk({tag, ".bottom"}, bottom, 0);
      chk({tag, ".sv"},     score_visitor, 0);
      chk({tag, ".sh"},     score_home, 0);
      chk({tag, ".rs"},     runs_scored, 0);
      chk({tag, ".sp"},     score_pulse, 0);
      chk({tag, ".cp"},     change_pulse, 0);
      chk({tag, ".go"},     game_over, 0);
   endtask

   initial begin
      reset_n   = 1'b0;
      hit_pulse = 4'd0;
      out_pulse = 1'b0;
      new_game  = 1'b0;

      //               hit   out   bases   outs  sv     rs    sp
      tbl[0]  = '{H1,     1'b0, 3'b001, 2'd0, 5'd0, 3'd0, 1'b1};
      tbl[1]  = '{H1,     1'b0, 3'b011, 2'd0, 5'd0, 3'd0, 1'b1};
      tbl[2]  = '{H1,     1'b0, 3'b111, 2'd0, 5'd0, 3'd0, 1'b1};
      tbl[3]  = '{H4,     1'b0, 3'b000, 2'd0, 5'd4, 3'd4, 1'b1};
      tbl[4]  = '{4'd0,   1'b0, 3'b000, 2'd0, 5'd4, 3'd0, 1'b0};
      tbl[5]  = '{H2,     1'b0, 3'b010, 2'd0, 5'd4, 3'd0, 1'b1};
      tbl[6]  = '{H1,     1'b0, 3'b101, 2'd0, 5'd4, 3'd0, 1'b1};
      tbl[7]  = '{H4,     1'b0, 3'b000, 2'd0, 5'd7, 3'd3, 1'b1};
      tbl[8]  = '{4'b0011,1'b0, 3'b000, 2'd0, 5'd7, 3'd0, 1'b0};
      tbl[9]  = '{H1,     1'b1, 3'b000, 2'd0, 5'd7, 3'd0, 1'b0};
      tbl[10] = '{H3,     1'b0, 3'b100, 2'd0, 5'd7, 3'd0, 1'b1};
      tbl[11] = '{H1,     1'b0, 3'b001, 2'd0, 5'd8, 3'd1, 1'b1};
      tbl[12] = '{4'd0,   1'b1, 3'b001, 2'd1, 5'd8, 3'd0, 1'b0};
      tbl[13] = '{4'd0,   1'b1, 3'b001, 2'd2, 5'd8, 3'd0, 1'b0};

      repeat (2) @(posedge clk);
      #1;
      chk_reset_state("reset");
      @(negedge clk);
      reset_n = 1'b1;

      // Top of the first inning, one event per vector
      for (int i = 0; i < 14; i++) begin
         apply(tbl[i].hit, tbl[i].out, 1'b0);
         chk($sformatf("v%0d.bases", i), bases, tbl[i].bases);
         chk($sformatf("v%0d.outs", i), outs, tbl[i].outs);
         chk($sformatf("v%0d.sv", i), score_visitor, tbl[i].sv);
         chk($sformatf("v%0d.sp", i), score_pulse, tbl[i].sp);
         chk($sformatf("v%0d.sh", i), score_home, 0);
         if (tbl[i].sp) chk($sformatf("v%0d.rs", i), runs_scored, tbl[i].rs);
      end

      // Third out: CHANGE cycle with bases held, then a hit in CHANGE is dropped
      apply(4'd0, 1'b1, 1'b0);
      chk("third.outs", outs, 3);
      chk("third.cp", change_pulse, 1);
      chk("third.bases", bases, 3'b001);
      chk("third.bottom", bottom, 0);
      apply(H1, 1'b0, 1'b0);
      chk("chg.outs", outs, 0);
      chk("chg.bases", bases, 0);
      chk("chg.bottom", bottom, 1);
      chk("chg.inning", inning, 1);
      chk("chg.cp", change_pulse, 0);
      chk("chg.sp", score_pulse, 0);
      chk("chg.sv", score_visitor, 8);
      chk("chg.sh", score_home, 0);

      // new_game mid-game clears everything on the next cycle
      apply(4'd0, 1'b0, 1'b1);
      chk_reset_state("newgame");

      // Async reset in the middle of a CHANGE cycle
      apply(H2, 1'b0, 1'b0);
      apply(4'd0, 1'b1, 1'b0);
      apply(4'd0, 1'b1, 1'b0);
      apply(4'd0, 1'b1, 1'b0);
      chk("arst.pre_cp", change_pulse, 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst.outs", outs, 0);
      chk("arst.cp", change_pulse, 0);
      chk("arst.bases", bases, 0);
      @(negedge clk);
      reset_n = 1'b1;
      apply(H2, 1'b0, 1'b0);
      chk("arst.after_bases", bases, 3'b010);
      chk("arst.after_sp", score_pulse, 1);

      // Home leads after the top of the last regulation inning: bottom skipped
      apply(4'd0, 1'b0, 1'b1);
      half_inning_outs();
      apply(H4, 1'b0, 1'b0);
      chk("skip.sh", score_home, 1);
      chk("skip.rs", runs_scored, 1);
      half_inning_outs();
      chk("skip.inning", inning, 2);
      chk("skip.bottom", bottom, 0);
      chk("skip.go_early", game_over, 0);
      apply(4'd0, 1'b1, 1'b0);
      apply(4'd0, 1'b1, 1'b0);
      apply(4'd0, 1'b1, 1'b0);
      chk("skip.cp", change_pulse, 1);
      apply(4'd0, 1'b0, 1'b0);
      chk("skip.go", game_over, 1);
      apply(H4, 1'b0, 1'b0);
      chk("over.sh", score_home, 1);
      chk("over.sv", score_visitor, 0);
      chk("over.sp", score_pulse, 0);
      apply(4'd0, 1'b1, 1'b0);
      chk("over.outs", outs, 0);
      chk("over.go", game_over, 1);

      // new_game together with an event: the event is dropped
      apply(H4, 1'b0, 1'b1);
      chk("ngev.sv", score_visitor, 0);
      chk("ngev.bases", bases, 0);
      chk("ngev.sp", score_pulse, 0);
      chk("ngev.go", game_over, 0);

      // Tie through regulation, extra inning, then a walk-off hit3
      apply(H4, 1'b0, 1'b0);
      half_inning_outs();
      apply(H4, 1'b0, 1'b0);
      half_inning_outs();
      chk("xtra.inning2", inning, 2);
      chk("xtra.go1", game_over, 0);
      half_inning_outs();
      chk("xtra.go_top2", game_over, 0);
      half_inning_outs();
      chk("xtra.inning3", inning, 3);
      chk("xtra.bottom", bottom, 0);
      chk("xtra.go_bot2", game_over, 0);
      half_inning_outs();
      apply(H1, 1'b0, 1'b0);
      chk("walk.bases1", bases, 3'b001);
      chk("walk.go_pre", game_over, 0);
      apply(H3, 1'b0, 1'b0);
      chk("walk.sh", score_home, 2);
      chk("walk.rs", runs_scored, 1);
      chk("walk.sp", score_pulse, 1);
      chk("walk.go", game_over, 1);
      chk("walk.bases", bases, 3'b100);
      apply(4'd0, 1'b0, 1'b0);
      chk("walk.sp_drop", score_pulse, 0);
      chk("walk.go_hold", game_over, 1);
      apply(H4, 1'b0, 1'b0);
      chk("walk.sh_hold", score_home, 2);

      // Score saturation: grand slams until the visitor register tops out
      apply(4'd0, 1'b0, 1'b1);
      for (int g = 0; g < 9; g++) begin
         apply(H1, 1'b0, 1'b0);
         apply(H1, 1'b0, 1'b0);
         apply(H1, 1'b0, 1'b0);
         apply(H4, 1'b0, 1'b0);
         chk($sformatf("sat%0d.sv", g), score_visitor, ((g + 1) * 4 > 31) ? 31 : (g + 1) * 4);
      end
      chk("sat.rs", runs_scored, 4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
